// File: rtl/fetch_queue.sv
// Instruction prefetch queue: streams sequential word fetches from a 1-cycle imem into a
// DEPTH-entry FIFO feeding IF/ID. Define FETCHQ_BYPASS_EN to let a response reach an empty queue's outputs directly.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt_in,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              pc_out,
  output logic [31:0]              pc4_out,
  output logic [31:0]              instr_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          squash;
  logic          halt_q;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;

  logic          halted;
  logic          issue;
  logic          resp_valid;
  logic          empty;
  logic          bypass_hit;
  logic          show;
  logic          push;
  logic          pop;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;

  // Issue credit counts the outstanding read, so its response always finds a free slot.
  assign halted     = halt_q | halt_in;
  assign issue      = !RST && !halted && ((cnt + (AW+1)'(inflight)) < DEPTH_C);
  assign resp_valid = inflight && !squash;
  assign empty      = (cnt == '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass_hit = resp_valid && empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign show      = !empty || bypass_hit;
  assign deq_valid = show && !redirect;
  assign pop       = deq_valid && deq_ready && !empty;
  // A bypassed response that is consumed in the same cycle never touches storage.
  assign push      = resp_valid && !redirect && !(bypass_hit && deq_ready);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_pc    = '0;
    head_instr = '0;
    if (!empty) begin
      head_pc    = pc_mem[rd_ptr];
      head_instr = instr_mem[rd_ptr];
    end else if (bypass_hit) begin
      head_pc    = inflight_pc;
      head_instr = imem_rdata;
    end
  end

  assign pc_out    = head_pc;
  assign instr_out = head_instr;
  assign pc4_out   = show ? head_pc + 32'd4 : 32'd0;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign count     = cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
      halt_q      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      halt_q   <= halt_q | halt_in;
      inflight <= issue;
      squash   <= redirect;
      if (issue) inflight_pc <= fetch_pc;

      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cnt      <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  wr_ptr   <= wr_ptr + AW'(1);
        if (pop)   rd_ptr   <= rd_ptr + AW'(1);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // NOTE: storage is not reset; slots are only read while count covers them, and outputs are zeroed when empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a transaction-level queue model predicts every output each cycle,
// plus directed scenario checks. Honors FETCHQ_BYPASS_EN when defined.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CW       = $clog2(DEPTH) + 1;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          halt_in = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          deq_ready = 1'b0;
  logic          deq_valid;
  logic [31:0]   pc_out;
  logic [31:0]   pc4_out;
  logic [31:0]   instr_out;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(clk), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .pc_out(pc_out), .pc4_out(pc4_out),
    .instr_out(instr_out), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  // Synchronous instruction memory: data for a request appears the following cycle.
  always @(posedge clk) imem_rdata <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_fetch_pc;
  logic        m_pend_v, m_pend_sq, m_halt;
  logic [31:0] m_pend_pc;
  int          cyc;

  int          o_cyc[$];
  logic [31:0] o_pc[$], o_pc4[$], o_ins[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_pend_v = 1'b0; m_pend_sq = 1'b0; m_pend_pc = '0; m_halt = 1'b0;
    cyc = 0;
    o_cyc.delete(); o_pc.delete(); o_pc4.delete(); o_ins.delete();
  endtask

  task automatic clear_obs();
    o_cyc.delete(); o_pc.delete(); o_pc4.delete(); o_ins.delete();
  endtask

  task automatic apply_reset();
    RST = 1'b1; redirect = 1'b0; halt_in = 1'b0; deq_ready = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    model_reset();
  endtask

  // One clock cycle starting at a falling edge: drive, compare against the model, advance the model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic hlt);
    logic e_req, e_resp, e_byp, e_valid, xfer;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic [CW-1:0] e_cnt;
    logic [31+32*4+CW+2:0] got, exp;
    deq_ready = rdy; redirect = redir; redirect_pc = tgt; halt_in = hlt;
    #1;
    e_req   = !(m_halt || hlt) && (m_q.size() + (m_pend_v ? 1 : 0) < DEPTH);
    e_resp  = m_pend_v && !m_pend_sq;
    e_byp   = BYP && e_resp && (m_q.size() == 0);
    e_valid = !redir && (m_q.size() != 0 || e_byp);
    e_cnt   = CW'(m_q.size());
    if (m_q.size() != 0) begin
      e_pc = m_q[0].pc; e_instr = m_q[0].instr;
    end else if (e_byp) begin
      e_pc = m_pend_pc; e_instr = word_at(m_pend_pc);
    end else begin
      e_pc = '0; e_instr = '0;
    end
    e_pc4 = (m_q.size() != 0 || e_byp) ? e_pc + 32'd4 : 32'd0;
    got = {deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out};
    exp = {e_valid, e_req, e_cnt, m_fetch_pc, e_pc, e_pc4, e_instr};
    n_total++;
    if (got !== exp)
      $display("FAIL cycle%0d model: got v=%b req=%b cnt=%0d addr=%h pc=%h pc4=%h ins=%h, expected v=%b req=%b cnt=%0d addr=%h pc=%h pc4=%h ins=%h",
               cyc, deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out,
               e_valid, e_req, e_cnt, m_fetch_pc, e_pc, e_pc4, e_instr);
    else n_pass++;
    if (deq_valid === 1'b1 && rdy) begin
      o_cyc.push_back(cyc); o_pc.push_back(pc_out); o_pc4.push_back(pc4_out); o_ins.push_back(instr_out);
    end
    @(posedge clk);
    xfer = e_valid && rdy;
    if (redir) m_q.delete();
    else begin
      if (xfer && m_q.size() != 0) void'(m_q.pop_front());
      if (e_resp && !(e_byp && rdy)) m_q.push_back('{pc: m_pend_pc, instr: word_at(m_pend_pc)});
    end
    m_pend_sq = redir;
    m_pend_pc = m_fetch_pc;
    m_pend_v  = e_req;
    if (redir)      m_fetch_pc = {tgt[31:2], 2'b00};
    else if (e_req) m_fetch_pc = m_fetch_pc + 32'd4;
    m_halt = m_halt || hlt;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    n_total++;
    if ({deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out} !== {2'b00, CW'(0), RESET_PC, 96'h0})
      $display("FAIL reset_values: got v=%b req=%b cnt=%0d addr=%h pc=%h pc4=%h ins=%h, expected all zero with addr=%h",
               deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out, RESET_PC);
    else n_pass++;
    @(negedge clk);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (o_pc.size() < 5 || o_cyc[0] != (BYP ? 1 : 2))
      $display("FAIL stream_first_valid: got %0d transfers, first at cycle %0d, expected >=5 with first at %0d",
               o_pc.size(), (o_cyc.size() != 0) ? o_cyc[0] : -1, BYP ? 1 : 2);
    else n_pass++;
    for (int i = 0; i < 5 && i < o_pc.size(); i++) begin
      n_total++;
      if (o_pc[i] !== RESET_PC + 32'(4*i) || o_pc4[i] !== RESET_PC + 32'(4*i+4) ||
          o_ins[i] !== word_at(RESET_PC + 32'(4*i)) || o_cyc[i] != o_cyc[0] + i)
        $display("FAIL stream_seq[%0d]: got pc=%h pc4=%h ins=%h cyc=%0d, expected pc=%h consecutive",
                 i, o_pc[i], o_pc4[i], o_ins[i], o_cyc[i], RESET_PC + 32'(4*i));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int base;
    apply_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
    #1;
    n_total++;
    if (count !== CW'(DEPTH) || imem_req !== 1'b0)
      $display("FAIL full_saturate: got count=%0d req=%b, expected count=%0d req=0", count, imem_req, DEPTH);
    else n_pass++;
    clear_obs();
    base = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (i >= o_pc.size() || o_pc[i] !== RESET_PC + 32'(4*i) || o_cyc[i] != base + i)
        $display("FAIL drain_seq[%0d]: got pc=%h cyc=%0d, expected pc=%h cyc=%0d", i,
                 (i < o_pc.size()) ? o_pc[i] : 32'hX, (i < o_cyc.size()) ? o_cyc[i] : -1,
                 RESET_PC + 32'(4*i), base + i);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    int r;
    bit bad;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
    #1;
    n_total++;
    if (count !== CW'(3)) $display("FAIL redirect_setup: got count=%0d, expected 3", count);
    else n_pass++;
    clear_obs();
    r = cyc;
    step(1'b1, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (o_pc.size() == 0 || o_pc[0] !== 32'h100 || o_ins[0] !== word_at(32'h100) || o_cyc[0] != r + (BYP ? 2 : 3))
      $display("FAIL redirect_first: got pc=%h ins=%h at cycle offset %0d, expected pc=00000100 at offset %0d",
               (o_pc.size() != 0) ? o_pc[0] : 32'hX, (o_ins.size() != 0) ? o_ins[0] : 32'hX,
               (o_cyc.size() != 0) ? o_cyc[0] - r : -1, BYP ? 2 : 3);
    else n_pass++;
    bad = 1'b0;
    foreach (o_pc[i]) if (o_pc[i] < 32'h100) bad = 1'b1;
    n_total++;
    if (bad) $display("FAIL redirect_squash: got a pre-redirect PC after redirect, expected none");
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    clear_obs();
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (o_pc.size() < 3 || o_pc[0] !== 32'hFFFF_FFF8 || o_pc[1] !== 32'hFFFF_FFFC || o_pc[2] !== 32'h0)
      $display("FAIL wrap_pcs: got %0d transfers pc0=%h pc1=%h pc2=%h, expected FFFFFFF8 FFFFFFFC 00000000",
               o_pc.size(), (o_pc.size() > 0) ? o_pc[0] : 32'hX, (o_pc.size() > 1) ? o_pc[1] : 32'hX,
               (o_pc.size() > 2) ? o_pc[2] : 32'hX);
    else n_pass++;
    n_total++;
    if (o_pc4.size() < 2 || o_pc4[0] !== 32'hFFFF_FFFC || o_pc4[1] !== 32'h0)
      $display("FAIL wrap_pc4: got pc4 %h %h, expected FFFFFFFC 00000000",
               (o_pc4.size() > 0) ? o_pc4[0] : 32'hX, (o_pc4.size() > 1) ? o_pc4[1] : 32'hX);
    else n_pass++;
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    clear_obs();
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (o_pc.size() != 3 || o_pc[0] !== RESET_PC || o_pc[2] !== RESET_PC + 32'd8)
      $display("FAIL halt_drain: got %0d transfers, expected 3 (PCs %h..%h)", o_pc.size(), RESET_PC, RESET_PC + 32'd8);
    else n_pass++;
    step(1'b1, 1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);
    #1;
    n_total++;
    if (deq_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h400)
      $display("FAIL halt_idle: got v=%b req=%b addr=%h, expected v=0 req=0 addr=00000400", deq_valid, imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    n_total++;
    if ({deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out} !== {2'b00, CW'(0), RESET_PC, 96'h0})
      $display("FAIL async_reset: got v=%b req=%b cnt=%0d addr=%h pc=%h pc4=%h ins=%h, expected reset values",
               deq_valid, imem_req, count, imem_addr, pc_out, pc4_out, instr_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (o_pc.size() == 0 || o_pc[0] !== RESET_PC || o_cyc[0] != (BYP ? 1 : 2))
      $display("FAIL reset_restart: got first pc=%h at cycle %0d, expected %h at %0d",
               (o_pc.size() != 0) ? o_pc[0] : 32'hX, (o_cyc.size() != 0) ? o_cyc[0] : -1, RESET_PC, BYP ? 1 : 2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic rdy, redir, hlt;
    logic [31:0] tgt;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 24) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      hlt   = (i > 700) && ($urandom_range(0, 39) == 0);
      step(rdy, redir, tgt, hlt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
